// File: rtl/frame_write_sequencer_pkg.sv
// Shared types for the instruction-frame write sequencer.
// State encoding is one-hot so the state register doubles as state_onehot.
package frame_ctrl_pkg;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    DECODE    = 5'b00010,
    SETUP     = 5'b00100,
    EXECUTE   = 5'b01000,
    WRITEBACK = 5'b10000
  } state_t;

  localparam int A_OPERAND   = 0;
  localparam int B_OPERAND   = 1;
  localparam int LOC         = 2;
  localparam int IMM         = 3;
  localparam int IMM_SLCT    = 4;
  localparam int UNSIGNED_OP = 5;
  localparam int SUB         = 6;
  localparam int SLCT        = 7;
  localparam int WR_EN0      = 8;
  localparam int WR_EN1      = 9;
  localparam int RESERVED    = 10;
  localparam int RESULT      = 11;

  localparam int DEF_FIELDS = 12;

  localparam logic [DEF_FIELDS-1:0] DEF_DECODE_MASK  = 12'h3FC;
  localparam logic [DEF_FIELDS-1:0] DEF_SETUP_MASK   = 12'h003;
  localparam logic [DEF_FIELDS-1:0] DEF_EXECUTE_MASK = 12'h800;
  localparam logic [DEF_FIELDS-1:0] DEF_WB_MASK      = 12'h800;

  function automatic logic isOneHot(input logic [4:0] s);
    return $onehot(s);
  endfunction

endpackage

// File: rtl/frame_write_sequencer_if.sv
// Control-unit <-> sequencer bundle: handshake, execute length,
// stall/flush controls and frame register write enables.
interface frame_write_sequencer_if #(
  parameter int NUM_FIELDS = 12,
  parameter int EXEC_CNT_W = 4,
  parameter int RETIRE_W   = 16
);
  logic                  start;
  logic                  ready;
  logic [EXEC_CNT_W-1:0] exec_cycles;
  logic                  stall;
  logic                  flush;
  logic [4:0]            state_onehot;
  logic [NUM_FIELDS-1:0] field_we;
  logic                  frame_done;
  logic [RETIRE_W-1:0]   retired_count;

  modport master (
    output start,
    output exec_cycles,
    output stall,
    output flush,
    input  ready,
    input  state_onehot,
    input  field_we,
    input  frame_done,
    input  retired_count
  );

  modport slave (
    input  start,
    input  exec_cycles,
    input  stall,
    input  flush,
    output ready,
    output state_onehot,
    output field_we,
    output frame_done,
    output retired_count
  );
endinterface

// File: rtl/frame_field_we_decoder.sv
// Maps the current sequencer state to per-field write enables.
// Any stall or flush suppresses every enable.
module frame_field_we_decoder
  import frame_ctrl_pkg::*;
#(
  parameter int NUM_FIELDS = 12,
  parameter logic [NUM_FIELDS-1:0] DECODE_MASK  = NUM_FIELDS'(DEF_DECODE_MASK),
  parameter logic [NUM_FIELDS-1:0] SETUP_MASK   = NUM_FIELDS'(DEF_SETUP_MASK),
  parameter logic [NUM_FIELDS-1:0] EXECUTE_MASK = NUM_FIELDS'(DEF_EXECUTE_MASK),
  parameter logic [NUM_FIELDS-1:0] WB_MASK      = NUM_FIELDS'(DEF_WB_MASK)
) (
  input  state_t                state,
  input  logic                  stall,
  input  logic                  flush,
  output logic [NUM_FIELDS-1:0] fieldWe
);

  logic [NUM_FIELDS-1:0] mask;
  logic [4:0]            stateBits;

  assign stateBits = state;

  always_comb begin
    mask = '0;
    unique case (1'b1)
      stateBits[0]: mask = '0;
      stateBits[1]: mask = DECODE_MASK;
      stateBits[2]: mask = SETUP_MASK;
      stateBits[3]: mask = EXECUTE_MASK;
      stateBits[4]: mask = WB_MASK;
      default:      mask = '0;
    endcase
  end

  assign fieldWe = mask & {NUM_FIELDS{~stall & ~flush}};

endmodule

// File: rtl/frame_write_sequencer.sv
// Instruction-frame lifecycle FSM with multi-cycle execute,
// stall/flush handling and a wrapping retired-frame counter.
module frame_write_sequencer
  import frame_ctrl_pkg::*;
#(
  parameter int NUM_FIELDS = 12,
  parameter int EXEC_CNT_W = 4,
  parameter int RETIRE_W   = 16,
  parameter logic [NUM_FIELDS-1:0] DECODE_MASK  = NUM_FIELDS'(DEF_DECODE_MASK),
  parameter logic [NUM_FIELDS-1:0] SETUP_MASK   = NUM_FIELDS'(DEF_SETUP_MASK),
  parameter logic [NUM_FIELDS-1:0] EXECUTE_MASK = NUM_FIELDS'(DEF_EXECUTE_MASK),
  parameter logic [NUM_FIELDS-1:0] WB_MASK      = NUM_FIELDS'(DEF_WB_MASK)
) (
  input logic                     clk,
  input logic                     reset_n,
  frame_write_sequencer_if.slave  bus
);

  state_t                state;
  state_t                stateNext;
  logic [EXEC_CNT_W-1:0] execCnt;
  logic [EXEC_CNT_W-1:0] execCntNext;
  logic [RETIRE_W-1:0]   retired;
  logic                  frameDone;
  logic                  active;

  assign active = ~bus.stall & ~bus.flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      execCnt <= '0;
      retired <= '0;
    end else begin
      state   <= stateNext;
      execCnt <= execCntNext;
      if (frameDone) retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    stateNext   = state;
    execCntNext = execCnt;
    frameDone   = 1'b0;
    if (bus.flush) begin
      stateNext   = IDLE;
      execCntNext = '0;
    end else if (!bus.stall) begin
      unique case (state)
        IDLE: begin
          if (bus.start) stateNext = DECODE;
        end
        DECODE: begin
          stateNext   = SETUP;
          execCntNext = bus.exec_cycles;
        end
        SETUP: begin
          stateNext = EXECUTE;
        end
        EXECUTE: begin
          if (execCnt != '0) begin
            execCntNext = execCnt - EXEC_CNT_W'(1);
          end else begin
            stateNext = WRITEBACK;
          end
        end
        WRITEBACK: begin
          frameDone = 1'b1;
          stateNext = bus.start ? DECODE : IDLE;
        end
        default: begin
          stateNext   = IDLE;
          execCntNext = '0;
        end
      endcase
    end
  end

  frame_field_we_decoder #(
    .NUM_FIELDS   (NUM_FIELDS),
    .DECODE_MASK  (DECODE_MASK),
    .SETUP_MASK   (SETUP_MASK),
    .EXECUTE_MASK (EXECUTE_MASK),
    .WB_MASK      (WB_MASK)
  ) u_weDec (
    .state   (state),
    .stall   (bus.stall),
    .flush   (bus.flush),
    .fieldWe (bus.field_we)
  );

  assign bus.state_onehot  = state;
  assign bus.frame_done    = frameDone;
  assign bus.retired_count = retired;
  assign bus.ready         = active &
                             ((state == IDLE) | (state == WRITEBACK));

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset_n) assert (isOneHot(state));
  end
`endif

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Directed self-checking bench for frame_write_sequencer.
// Retire counter narrowed to 4 bits so the wrap case stays short.
module tb_frame_write_sequencer;

  localparam int NF = 12;
  localparam int EW = 4;
  localparam int RW = 4;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_DEC  = 5'b00010;
  localparam logic [4:0] S_SET  = 5'b00100;
  localparam logic [4:0] S_EXE  = 5'b01000;
  localparam logic [4:0] S_WB   = 5'b10000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   nTests = 0;
  int   nFail = 0;

  frame_write_sequencer_if #(
    .NUM_FIELDS (NF),
    .EXEC_CNT_W (EW),
    .RETIRE_W   (RW)
  ) bus ();

  frame_write_sequencer #(
    .NUM_FIELDS (NF),
    .EXEC_CNT_W (EW),
    .RETIRE_W   (RW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nTests++;
    assert (got === exp) else begin
      nFail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chkState(input string tag,
                          input logic [4:0] st,
                          input logic [NF-1:0] we);
    chk({tag, ".state"}, 32'(bus.state_onehot), 32'(st));
    chk({tag, ".we"}, 32'(bus.field_we), 32'(we));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.exec_cycles = '0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    #12;
    chkState("rst", S_IDLE, 12'h000);
    chk("rst.ready", 32'(bus.ready), 32'd1);
    chk("rst.done", 32'(bus.frame_done), 32'd0);
    chk("rst.ret", 32'(bus.retired_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // single minimum-length frame
    bus.start = 1'b1;
    #1;
    chk("f1.ready", 32'(bus.ready), 32'd1);
    tick();
    bus.start = 1'b0;
    #1;
    chkState("f1.dec", S_DEC, 12'h3FC);
    chk("f1.dec.ready", 32'(bus.ready), 32'd0);
    tick();
    chkState("f1.set", S_SET, 12'h003);
    tick();
    chkState("f1.exe", S_EXE, 12'h800);
    tick();
    chkState("f1.wb", S_WB, 12'h800);
    chk("f1.wb.done", 32'(bus.frame_done), 32'd1);
    chk("f1.wb.ready", 32'(bus.ready), 32'd1);
    tick();
    chkState("f1.idle", S_IDLE, 12'h000);
    chk("f1.done0", 32'(bus.frame_done), 32'd0);
    chk("f1.ret", 32'(bus.retired_count), 32'd1);

    // exec_cycles=3: EXECUTE for four cycles
    bus.exec_cycles = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    chkState("f2.dec", S_DEC, 12'h3FC);
    tick();
    chkState("f2.set", S_SET, 12'h003);
    for (int i = 0; i < 4; i++) begin
      tick();
      chkState($sformatf("f2.exe%0d", i), S_EXE, 12'h800);
      chk("f2.exe.done", 32'(bus.frame_done), 32'd0);
    end
    tick();
    chkState("f2.wb", S_WB, 12'h800);
    chk("f2.wb.done", 32'(bus.frame_done), 32'd1);
    bus.exec_cycles = '0;
    tick();
    chk("f2.ret", 32'(bus.retired_count), 32'd2);

    // three back-to-back frames, no IDLE bubble
    bus.start = 1'b1;
    for (int f = 0; f < 3; f++) begin
      tick();
      chkState($sformatf("b2b%0d.dec", f), S_DEC, 12'h3FC);
      tick();
      tick();
      tick();
      chkState($sformatf("b2b%0d.wb", f), S_WB, 12'h800);
      chk($sformatf("b2b%0d.done", f), 32'(bus.frame_done), 32'd1);
      chk($sformatf("b2b%0d.ret", f), 32'(bus.retired_count), 32'(2 + f));
    end
    bus.start = 1'b0;
    tick();
    chkState("b2b.idle", S_IDLE, 12'h000);
    chk("b2b.ret", 32'(bus.retired_count), 32'd5);

    // two-cycle stall in SETUP
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.stall = 1'b1;
    #1;
    chkState("stl.c0", S_SET, 12'h000);
    chk("stl.ready", 32'(bus.ready), 32'd0);
    tick();
    chkState("stl.c1", S_SET, 12'h000);
    bus.stall = 1'b0;
    #1;
    chkState("stl.rel", S_SET, 12'h003);
    tick();
    chkState("stl.exe", S_EXE, 12'h800);
    tick();
    tick();
    chk("stl.ret", 32'(bus.retired_count), 32'd6);

    // flush in EXECUTE with start asserted
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chkState("fl.exe", S_EXE, 12'h800);
    bus.flush = 1'b1;
    bus.start = 1'b1;
    #1;
    chk("fl.we", 32'(bus.field_we), 32'd0);
    chk("fl.done", 32'(bus.frame_done), 32'd0);
    chk("fl.ready", 32'(bus.ready), 32'd0);
    tick();
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    chkState("fl.idle", S_IDLE, 12'h000);
    chk("fl.ret", 32'(bus.retired_count), 32'd6);

    // asynchronous reset mid-EXECUTE
    bus.exec_cycles = 4'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chkState("ar.exe", S_EXE, 12'h800);
    #2;
    reset_n = 1'b0;
    #1;
    chkState("ar.rst", S_IDLE, 12'h000);
    chk("ar.ready", 32'(bus.ready), 32'd1);
    chk("ar.ret", 32'(bus.retired_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.exec_cycles = '0;
    tick();

    // stall in IDLE blocks start
    bus.stall = 1'b1;
    bus.start = 1'b1;
    #1;
    chk("si.ready", 32'(bus.ready), 32'd0);
    tick();
    chkState("si.idle", S_IDLE, 12'h000);
    bus.stall = 1'b0;
    bus.start = 1'b0;
    #1;

    // retired counter wraps 15 -> 0
    bus.start = 1'b1;
    repeat (60) tick();
    chkState("wr.wb15", S_WB, 12'h800);
    bus.start = 1'b0;
    tick();
    chk("wr.max", 32'(bus.retired_count), 32'hF);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    chk("wr.wb16.done", 32'(bus.frame_done), 32'd1);
    tick();
    chk("wr.zero", 32'(bus.retired_count), 32'd0);
    chkState("wr.idle", S_IDLE, 12'h000);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
